// File: rtl/serial_add_sub_if.sv
// Bundle of the serial adder/subtractor request and result signals.
//
// Handshake: the master raises start together with a, b and sub; the block
// accepts them only on a rising edge where it is IDLE (busy low). Requests
// presented while busy are ignored and not queued. Completion is signalled by
// a one-cycle done pulse; sum, carryout and overflow are valid from that edge
// and are held until the next accepted operation completes.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic [1:0]       state_dbg;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carryout, overflow, state_dbg
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carryout, overflow, state_dbg
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder stage, operands consumed LSB
// first, WIDTH cycles from accept to done.
// Optional feature macro: SERIAL_ADD_SUB_OVERFLOW_EN enables signed overflow
// detection; without it overflow is tied to 0.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  serial_add_sub_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Partial result: bits already computed, MSB-aligned; the final bit is
  // concatenated on top at the last step so this needs only WIDTH-1 bits.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Single full-adder stage operating on the current LSBs.
  logic b_bit;
  logic sum_bit;
  logic carry_next;
  logic last_step;

  assign b_bit      = b_q[0] ^ sub_q;
  assign sum_bit    = a_q[0] ^ b_bit ^ carry_q;
  assign carry_next = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
  assign last_step  = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath control for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          cnt_d   = '0;
          // Carry-in of 1 completes the two's-complement negation of b.
          carry_d = bus.sub;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_next;
        res_d   = (WIDTH-1)'({sum_bit, res_q} >> 1);
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d = S_DONE;
          sum_d   = {sum_bit, res_q};
          cout_d  = carry_next;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // At the last step carry_q is the carry into the MSB stage and carry_next
  // the carry out of it; they differ exactly on signed overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last_step) begin
      ovf_d = carry_q ^ carry_next;
    end
  end

  // Overflow flag register, updated only at the done edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carryout  = cout_q;
  assign bus.state_dbg = state_q;

endmodule
